// File: rtl/mult_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit_if                                                     |
// | Request/result bundle between the EX-stage control and the MDU.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface mult_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             op_div;
  logic             op_sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, op_sign, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op_div, op_sign, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit                                                        |
// | Multi-cycle radix-2 multiply/divide unit with HI/LO registers.       |
// | Divide datapath is built only when MDU_DIV_EN is defined.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opm;
  logic                 r_neg_q;
  logic                 r_done;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_start_ok;
  logic                 w_launch;
  logic                 w_nodiv;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_mstep;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;
  logic                 w_fix_dz;

  assign w_start_ok = (r_state == S_IDLE) && bus.start && !bus.flush;

`ifdef MDU_DIV_EN
  logic                 r_is_div;
  logic                 r_neg_r;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH:0]       w_rem;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_dstep;

  assign w_launch = w_start_ok;
  assign w_nodiv  = 1'b0;

  // Restoring step: borrow out of the (WIDTH+1)-bit subtract means "keep remainder"
  assign w_rem   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_rem - {1'b0, r_opm};
  assign w_ge    = ~w_diff[WIDTH];
  assign w_dstep = {(w_ge ? w_diff[WIDTH-1:0] : w_rem[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
`else
  assign w_launch = w_start_ok && !bus.op_div;
  assign w_nodiv  = w_start_ok && bus.op_div;
`endif

  assign w_a_neg = bus.op_sign & bus.a[WIDTH-1];
  assign w_b_neg = bus.op_sign & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag = w_b_neg ? (~bus.b + 1'b1) : bus.b;

  // Multiplier sits in the low half and shifts out as partial sums shift in
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opm} : {(WIDTH+1){1'b0}});
  assign w_mstep = {w_msum, r_acc[WIDTH-1:1]};

  always_comb begin
    w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    w_fix_dz = 1'b0;
`ifdef MDU_DIV_EN
    if (r_is_div) begin
      w_fix_dz = r_dz;
      if (r_dz) begin
        w_fix_hi = r_dvd;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_fix_hi = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_launch) w_next = S_CALC;
        S_CALC:  if (r_cnt == CNT_W'(WIDTH)) w_next = S_FIX;
        S_FIX:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opm   <= '0;
      r_neg_q <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_dvd    <= '0;
`endif
    end else if (r_state == S_IDLE) begin
      if (w_launch) begin
        r_cnt   <= '0;
        r_neg_q <= bus.op_sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MDU_DIV_EN
        r_is_div <= bus.op_div;
        r_neg_r  <= w_a_neg;
        r_dz     <= bus.op_div && (bus.b == '0);
        r_dvd    <= bus.a;
        if (bus.op_div) begin
          r_acc <= {{WIDTH{1'b0}}, w_a_mag};
          r_opm <= w_b_mag;
        end else begin
          r_acc <= {{WIDTH{1'b0}}, w_b_mag};
          r_opm <= w_a_mag;
        end
`else
        r_acc <= {{WIDTH{1'b0}}, w_b_mag};
        r_opm <= w_a_mag;
`endif
      end
    end else if (r_state == S_CALC && r_cnt != CNT_W'(WIDTH)) begin
      r_cnt <= r_cnt + 1'b1;
`ifdef MDU_DIV_EN
      r_acc <= r_is_div ? w_dstep : w_mstep;
`else
      r_acc <= w_mstep;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if (r_state == S_FIX && !bus.flush) begin
        r_hi       <= w_fix_hi;
        r_lo       <= w_fix_lo;
        r_done     <= 1'b1;
        r_div_zero <= w_fix_dz;
      end else if (r_state == S_IDLE) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
        r_done <= w_nodiv;
      end
    end
  end

  assign bus.busy     = (r_state == S_CALC);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule
`default_nettype wire
